// File: rtl/axis_stream_monitor_pkg.sv
// Shared definitions for the AXI4-Stream monitor: Wishbone register map,
// identification word and the frame-tracking state type.
package axis_stream_monitor_pkg;

    localparam logic [7:0] REG_FRAMES     = 8'h00;
    localparam logic [7:0] REG_BAD_FRAMES = 8'h01;
    localparam logic [7:0] REG_RUNTS      = 8'h02;
    localparam logic [7:0] REG_BYTES_LO   = 8'h03;
    localparam logic [7:0] REG_BYTES_HI   = 8'h04;
    localparam logic [7:0] REG_MAX_LEN    = 8'h05;
    localparam logic [7:0] REG_STALLS     = 8'h06;
    localparam logic [7:0] REG_STALL_FLAG = 8'h07;
    localparam logic [7:0] REG_ID         = 8'h08;

    // ASCII "STM1"
    localparam logic [31:0] MON_ID = 32'h5354_4D31;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } mon_state_t;

endpackage

// File: rtl/axis_stream_monitor_keep_popcount.sv
// Counts the set bits of a tkeep vector (number of valid bytes in a beat).
// Ports:
//   keep   in   KEEP_WIDTH    byte enables
//   count  out  COUNT_WIDTH   number of ones in keep
module axis_stream_monitor_keep_popcount #(
    parameter int KEEP_WIDTH  = 16,
    parameter int COUNT_WIDTH = $clog2(KEEP_WIDTH) + 1
) (
    input  logic [KEEP_WIDTH-1:0]  keep,
    output logic [COUNT_WIDTH-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            count = count + COUNT_WIDTH'(keep[i]);
        end
    end

endmodule

// File: rtl/axis_stream_monitor.sv
// Zero-latency AXI4-Stream pass-through that gathers frame statistics
// (frames, FCS-bad frames, runts, bytes, max frame length, stall events)
// and exposes them as read-only Wishbone registers.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_t* / s_tready               upstream stream (s_tready = m_tready)
//   m_t* / m_tready               downstream stream (m_t* = s_t*)
//   wb_adr/dat_i/dat_o/we/stb/cyc/ack   Wishbone classic register port
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | between frames; next accepted beat starts a frame
// IN_FRAME | at least one non-last beat of a frame accepted
module axis_stream_monitor
    import axis_stream_monitor_pkg::*;
#(
    parameter int DATA_WIDTH    = 128,
    parameter int CNT_WIDTH     = 32,
    parameter int LEN_WIDTH     = 16,
    parameter int RUNT_BYTES    = 64,
    parameter int STALL_TIMEOUT = 1024,
    localparam int KEEP_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    input  logic                  s_tuser,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    output logic                  m_tuser,
    input  logic                  m_tready,
    input  logic [7:0]            wb_adr,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_we,
    input  logic                  wb_stb,
    input  logic                  wb_cyc,
    output logic                  wb_ack
);

    localparam int PC_WIDTH = $clog2(KEEP_WIDTH) + 1;
    localparam int ST_WIDTH = $clog2(STALL_TIMEOUT + 1);

    assign m_tdata  = s_tdata;
    assign m_tkeep  = s_tkeep;
    assign m_tvalid = s_tvalid;
    assign m_tlast  = s_tlast;
    assign m_tuser  = s_tuser;
    assign s_tready = m_tready;

    logic [PC_WIDTH-1:0] keep_cnt;

    axis_stream_monitor_keep_popcount #(
        .KEEP_WIDTH  (KEEP_WIDTH),
        .COUNT_WIDTH (PC_WIDTH)
    ) u_popcount (
        .keep  (s_tkeep),
        .count (keep_cnt)
    );

    mon_state_t             state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_acc_q, len_acc_d;
    logic [CNT_WIDTH-1:0]   frames_q, frames_d;
    logic [CNT_WIDTH-1:0]   bad_frames_q, bad_frames_d;
    logic [CNT_WIDTH-1:0]   runts_q, runts_d;
    logic [2*CNT_WIDTH-1:0] bytes_q, bytes_d;
    logic [LEN_WIDTH-1:0]   max_len_q, max_len_d;
    logic [CNT_WIDTH-1:0]   stalls_q, stalls_d;
    logic                   stall_flag_q, stall_flag_d;
    logic [ST_WIDTH-1:0]    stall_ctr_q, stall_ctr_d;
    logic [CNT_WIDTH-1:0]   bytes_hi_q, bytes_hi_d;
    logic                   wb_ack_q, wb_ack_d;
    logic [31:0]            wb_dat_q, wb_dat_d;

    logic                   beat, stall, stall_evt;
    logic                   wb_req, clear;
    logic [LEN_WIDTH:0]     len_sum;
    logic [LEN_WIDTH-1:0]   final_len;
    logic [2*CNT_WIDTH:0]   bytes_sum;
    logic [31:0]            rd_data;
    logic                   unused_wb_dat;

    assign unused_wb_dat = ^wb_dat_i[31:1];

    assign beat   = s_tvalid && m_tready;
    assign stall  = s_tvalid && !m_tready;
    // The counter parks at STALL_TIMEOUT, so the compare fires once per episode.
    assign stall_evt = stall && (stall_ctr_q == ST_WIDTH'(STALL_TIMEOUT - 1));

    assign wb_req = wb_cyc && wb_stb && !wb_ack_q;
    assign clear  = wb_req && wb_we && (wb_adr == REG_STALL_FLAG) && wb_dat_i[0];

    assign len_sum   = {1'b0, len_acc_q} + (LEN_WIDTH + 1)'(keep_cnt);
    assign final_len = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];
    assign bytes_sum = {1'b0, bytes_q} + (2 * CNT_WIDTH + 1)'(keep_cnt);

    always_comb begin
        state_d      = state_q;
        len_acc_d    = len_acc_q;
        frames_d     = frames_q;
        bad_frames_d = bad_frames_q;
        runts_d      = runts_q;
        bytes_d      = bytes_q;
        max_len_d    = max_len_q;
        stalls_d     = stalls_q;
        stall_flag_d = stall_flag_q;
        stall_ctr_d  = stall_ctr_q;

        case (state_q)
            IDLE:     if (beat && !s_tlast) state_d = IN_FRAME;
            IN_FRAME: if (beat && s_tlast)  state_d = IDLE;
        endcase

        if (beat) begin
            bytes_d = bytes_sum[2*CNT_WIDTH] ? '1 : bytes_sum[2*CNT_WIDTH-1:0];
            if (s_tlast) begin
                len_acc_d = '0;
                if (frames_q != '1) frames_d = frames_q + CNT_WIDTH'(1);
                if (s_tuser && bad_frames_q != '1) bad_frames_d = bad_frames_q + CNT_WIDTH'(1);
                if (int'(final_len) < RUNT_BYTES && runts_q != '1) runts_d = runts_q + CNT_WIDTH'(1);
                if (final_len > max_len_q) max_len_d = final_len;
            end else begin
                len_acc_d = final_len;
            end
        end

        if (!stall) begin
            stall_ctr_d = '0;
        end else if (stall_ctr_q != ST_WIDTH'(STALL_TIMEOUT)) begin
            stall_ctr_d = stall_ctr_q + ST_WIDTH'(1);
        end

        if (stall_evt) begin
            if (stalls_q != '1) stalls_d = stalls_q + CNT_WIDTH'(1);
            stall_flag_d = 1'b1;
        end

        // Clear overrides any event landing in the same cycle.
        if (clear) begin
            len_acc_d    = '0;
            frames_d     = '0;
            bad_frames_d = '0;
            runts_d      = '0;
            bytes_d      = '0;
            max_len_d    = '0;
            stalls_d     = '0;
            stall_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_acc_q    <= '0;
            frames_q     <= '0;
            bad_frames_q <= '0;
            runts_q      <= '0;
            bytes_q      <= '0;
            max_len_q    <= '0;
            stalls_q     <= '0;
            stall_flag_q <= 1'b0;
            stall_ctr_q  <= '0;
        end else begin
            state_q      <= state_d;
            len_acc_q    <= len_acc_d;
            frames_q     <= frames_d;
            bad_frames_q <= bad_frames_d;
            runts_q      <= runts_d;
            bytes_q      <= bytes_d;
            max_len_q    <= max_len_d;
            stalls_q     <= stalls_d;
            stall_flag_q <= stall_flag_d;
            stall_ctr_q  <= stall_ctr_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (wb_adr)
            REG_FRAMES:     rd_data[CNT_WIDTH-1:0] = frames_q;
            REG_BAD_FRAMES: rd_data[CNT_WIDTH-1:0] = bad_frames_q;
            REG_RUNTS:      rd_data[CNT_WIDTH-1:0] = runts_q;
            REG_BYTES_LO:   rd_data[CNT_WIDTH-1:0] = bytes_q[CNT_WIDTH-1:0];
            REG_BYTES_HI:   rd_data[CNT_WIDTH-1:0] = bytes_hi_q;
            REG_MAX_LEN:    rd_data[LEN_WIDTH-1:0] = max_len_q;
            REG_STALLS:     rd_data[CNT_WIDTH-1:0] = stalls_q;
            REG_STALL_FLAG: rd_data[0]             = stall_flag_q;
            REG_ID:         rd_data                = MON_ID;
            default:        rd_data                = '0;
        endcase
    end

    always_comb begin
        wb_ack_d   = wb_req;
        wb_dat_d   = wb_req ? rd_data : '0;
        bytes_hi_d = bytes_hi_q;
        // Reading the low word snapshots the high word for a coherent 64-bit read.
        if (wb_req && !wb_we && wb_adr == REG_BYTES_LO) bytes_hi_d = bytes_q[2*CNT_WIDTH-1:CNT_WIDTH];
        if (clear) bytes_hi_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_q   <= 1'b0;
            wb_dat_q   <= '0;
            bytes_hi_q <= '0;
        end else begin
            wb_ack_q   <= wb_ack_d;
            wb_dat_q   <= wb_dat_d;
            bytes_hi_q <= bytes_hi_d;
        end
    end

    assign wb_ack   = wb_ack_q;
    assign wb_dat_o = wb_dat_q;

endmodule

// File: tb/tb_axis_stream_monitor.sv
module tb_axis_stream_monitor;
    import axis_stream_monitor_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [127:0] s_tdata;
    logic [15:0]  s_tkeep;
    logic         s_tvalid, s_tlast, s_tuser, m_tready;
    logic [7:0]   wb_adr;
    logic [31:0]  wb_dat_i;
    logic         wb_we, wb_stb, wb_cyc;

    logic         s_tready_a, m_tvalid_a, m_tlast_a, m_tuser_a, wb_ack_a;
    logic [127:0] m_tdata_a;
    logic [15:0]  m_tkeep_a;
    logic [31:0]  wb_dat_o_a;

    logic         s_tready_b, m_tvalid_b, m_tlast_b, m_tuser_b, wb_ack_b;
    logic [127:0] m_tdata_b;
    logic [15:0]  m_tkeep_b;
    logic [31:0]  wb_dat_o_b;

    logic sel_b;
    int   checks = 0;
    int   errors = 0;

    axis_stream_monitor dut_a (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tuser(s_tuser), .s_tready(s_tready_a),
        .m_tdata(m_tdata_a), .m_tkeep(m_tkeep_a), .m_tvalid(m_tvalid_a), .m_tlast(m_tlast_a),
        .m_tuser(m_tuser_a), .m_tready(m_tready),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o_a),
        .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_ack(wb_ack_a)
    );

    // Narrow-counter instance: makes saturation and the 64-bit carry reachable.
    axis_stream_monitor #(.CNT_WIDTH(8), .LEN_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tuser(s_tuser), .s_tready(s_tready_b),
        .m_tdata(m_tdata_b), .m_tkeep(m_tkeep_b), .m_tvalid(m_tvalid_b), .m_tlast(m_tlast_b),
        .m_tuser(m_tuser_b), .m_tready(m_tready),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o_b),
        .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_ack(wb_ack_b)
    );

    typedef struct {
        int         nfr;
        int         nbeats;
        logic [15:0] last_keep;
        logic       user;
        int         e_frames;
        int         e_bad;
        int         e_runts;
        int         e_bytes;
        int         e_max;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic [7:0] adr, input logic we, input logic [31:0] dat,
                           output logic [31:0] rdata);
        logic got;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
        got = 1'b0;
        rdata = '0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (sel_b ? wb_ack_b : wb_ack_a) begin
                got = 1'b1;
                rdata = sel_b ? wb_dat_o_b : wb_dat_o_a;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wb_ack timeout: adr 0x%0h got no ack, expected ack within 4 cycles", adr);
        end
    endtask

    task automatic rd_check(input string name, input logic [7:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(adr, 1'b0, 32'h0, d);
        check(name, {32'h0, d}, {32'h0, exp});
    endtask

    task automatic clear_all();
        logic [31:0] d;
        wb_xfer(REG_STALL_FLAG, 1'b1, 32'h1, d);
    endtask

    task automatic send_beat(input logic [15:0] keep, input logic last, input logic user);
        logic ok;
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = {$urandom, $urandom, $urandom, $urandom};
        s_tkeep  = keep;
        s_tlast  = last;
        s_tuser  = user;
        m_tready = 1'b1;
        #1;
        ok = (m_tdata_a === s_tdata) && (m_tkeep_a === s_tkeep) && (m_tvalid_a === s_tvalid) &&
             (m_tlast_a === s_tlast) && (m_tuser_a === s_tuser) && (s_tready_a === m_tready);
        check("passthrough", {63'h0, ok}, 64'h1);
        @(posedge clk);
    endtask

    task automatic stream_idle();
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tkeep = '0;
    endtask

    task automatic send_frame(input int nbeats, input logic [15:0] last_keep, input logic user);
        for (int i = 0; i < nbeats - 1; i++) send_beat(16'hFFFF, 1'b0, 1'b0);
        send_beat(last_keep, 1'b1, user);
        stream_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3, 4, 16'hFFFF, 1'b0, 3, 0, 0, 192, 64};
        vecs[1] = '{1, 4, 16'h0FFF, 1'b1, 1, 1, 1, 60, 60};
        vecs[2] = '{1, 1, 16'h0001, 1'b0, 1, 0, 1, 1, 1};
        vecs[3] = '{2, 5, 16'h00FF, 1'b0, 2, 0, 0, 144, 72};
        vecs[4] = '{1, 4, 16'h7FFF, 1'b1, 1, 1, 1, 63, 63};

        sel_b = 1'b0;
        rst = 1'b1;
        s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        m_tready = 1'b1;
        wb_adr = '0; wb_dat_i = '0; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset wb_ack", {63'h0, wb_ack_a}, 64'h0);
        check("reset wb_dat_o", {32'h0, wb_dat_o_a}, 64'h0);
        check("reset state", {63'h0, dut_a.state_q == IDLE}, 64'h1);
        rd_check("reset frames", REG_FRAMES, 32'h0);
        rd_check("reset bytes_lo", REG_BYTES_LO, 32'h0);

        // Table-driven frame scenarios
        for (int v = 0; v < 5; v++) begin
            clear_all();
            for (int f = 0; f < vecs[v].nfr; f++)
                send_frame(vecs[v].nbeats, vecs[v].last_keep, vecs[v].user);
            rd_check($sformatf("vec%0d frames", v), REG_FRAMES, 32'(vecs[v].e_frames));
            rd_check($sformatf("vec%0d bad_frames", v), REG_BAD_FRAMES, 32'(vecs[v].e_bad));
            rd_check($sformatf("vec%0d runts", v), REG_RUNTS, 32'(vecs[v].e_runts));
            rd_check($sformatf("vec%0d bytes_lo", v), REG_BYTES_LO, 32'(vecs[v].e_bytes));
            rd_check($sformatf("vec%0d bytes_hi", v), REG_BYTES_HI, 32'h0);
            rd_check($sformatf("vec%0d max_len", v), REG_MAX_LEN, 32'(vecs[v].e_max));
        end

        // Stall episodes
        clear_all();
        @(negedge clk);
        s_tvalid = 1'b1; s_tkeep = 16'hFFFF; s_tlast = 1'b1; m_tready = 1'b0;
        repeat (2500) @(posedge clk);
        rd_check("stalls after long episode", REG_STALLS, 32'h1);
        rd_check("stall_flag set", REG_STALL_FLAG, 32'h1);
        @(negedge clk); m_tready = 1'b1;
        @(negedge clk); m_tready = 1'b0;
        repeat (1024) @(posedge clk);
        @(negedge clk); m_tready = 1'b1;
        @(negedge clk); m_tready = 1'b0;
        repeat (1023) @(posedge clk);
        @(negedge clk); m_tready = 1'b1;
        @(negedge clk); s_tvalid = 1'b0; s_tlast = 1'b0;
        rd_check("stalls after 1024 and 1023", REG_STALLS, 32'h2);
        rd_check("stall_flag sticky", REG_STALL_FLAG, 32'h1);

        // Clear coinciding with a tlast beat
        send_frame(2, 16'hFFFF, 1'b1);
        for (int i = 0; i < 3; i++) send_beat(16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
        s_tvalid = 1'b1; s_tkeep = 16'hFFFF; s_tlast = 1'b1; s_tuser = 1'b1; m_tready = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = REG_STALL_FLAG; wb_dat_i = 32'h1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        check("clear ack high", {63'h0, wb_ack_a}, 64'h1);
        @(posedge clk);
        #1;
        check("clear ack one cycle", {63'h0, wb_ack_a}, 64'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        rd_check("clear frames", REG_FRAMES, 32'h0);
        rd_check("clear bad_frames", REG_BAD_FRAMES, 32'h0);
        rd_check("clear runts", REG_RUNTS, 32'h0);
        rd_check("clear bytes_lo", REG_BYTES_LO, 32'h0);
        rd_check("clear bytes_hi", REG_BYTES_HI, 32'h0);
        rd_check("clear max_len", REG_MAX_LEN, 32'h0);
        rd_check("clear stalls", REG_STALLS, 32'h0);
        rd_check("clear stall_flag", REG_STALL_FLAG, 32'h0);
        send_frame(1, 16'hFFFF, 1'b0);
        rd_check("post-clear frames", REG_FRAMES, 32'h1);
        rd_check("post-clear max_len", REG_MAX_LEN, 32'd16);

        // Carry coherence and saturation on the narrow instance
        clear_all();
        sel_b = 1'b1;
        for (int i = 0; i < 15; i++) send_frame(1, 16'hFFFF, 1'b0);
        rd_check("narrow bytes_lo 240", REG_BYTES_LO, 32'hF0);
        send_frame(1, 16'hFFFF, 1'b0);
        send_frame(1, 16'hFFFF, 1'b0);
        rd_check("narrow bytes_hi shadow", REG_BYTES_HI, 32'h0);
        rd_check("narrow bytes_lo 272", REG_BYTES_LO, 32'h10);
        rd_check("narrow bytes_hi 272", REG_BYTES_HI, 32'h1);
        for (int i = 0; i < 250; i++) send_frame(1, 16'hFFFF, 1'b0);
        rd_check("narrow frames saturate", REG_FRAMES, 32'hFF);
        send_frame(1, 16'hFFFF, 1'b0);
        rd_check("narrow frames no wrap", REG_FRAMES, 32'hFF);
        rd_check("narrow bytes_lo 4288", REG_BYTES_LO, 32'hC0);
        rd_check("narrow bytes_hi 4288", REG_BYTES_HI, 32'h10);
        send_frame(17, 16'hFFFF, 1'b0);
        rd_check("narrow max_len saturates", REG_MAX_LEN, 32'hFF);
        sel_b = 1'b0;
        rd_check("wide max_len 272", REG_MAX_LEN, 32'd272);
        rd_check("wide frames 269", REG_FRAMES, 32'd269);

        // Reset in the middle of a frame
        send_beat(16'hFFFF, 1'b0, 1'b0);
        send_beat(16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        s_tvalid = 1'b1; s_tkeep = 16'hFFFF; s_tlast = 1'b0; m_tready = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = REG_ID;
        #1;
        check("reset passthrough tvalid", {63'h0, m_tvalid_a}, 64'h1);
        check("reset passthrough tready", {63'h0, s_tready_a}, 64'h1);
        @(posedge clk);
        #1;
        check("reset holds ack low", {63'h0, wb_ack_a}, 64'h0);
        check("reset holds dat_o zero", {32'h0, wb_dat_o_a}, 64'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        s_tvalid = 1'b0;
        check("mid-frame reset state", {63'h0, dut_a.state_q == IDLE}, 64'h1);
        rd_check("mid-frame reset frames", REG_FRAMES, 32'h0);
        send_frame(2, 16'hFFFF, 1'b0);
        rd_check("restart frames", REG_FRAMES, 32'h1);
        rd_check("restart bytes", REG_BYTES_LO, 32'd32);
        rd_check("restart max_len", REG_MAX_LEN, 32'd32);
        rd_check("restart runts", REG_RUNTS, 32'h1);
        check("restart state idle", {63'h0, dut_a.state_q == IDLE}, 64'h1);
        rd_check("id register", REG_ID, 32'h5354_4D31);
        rd_check("unmapped address", 8'h20, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
